// File: rtl/exec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exec_sequencer_pkg
//
// Shared constants for the multi-cycle execution sequencer:
//   - state_e          : sequencer state encoding (also visible on state_o)
//   - PC_SEL_*         : next-PC selector values (PC+4 or branch/jump target)
//   - WAIT_CNT_W       : width of the memory-acknowledge wait counter; sized
//                        so any timeout in 1..255 fits
//   - is_wait_state()  : true in the states that wait for a memory acknowledge
// -----------------------------------------------------------------------------
package exec_sequencer_pkg;

    // Sequencer state encoding. The numeric values are architecturally
    // visible through state_o, so they must not be reordered.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Next-PC selector: 0 = sequential PC+4, 1 = computed target.
    localparam logic PC_SEL_PLUS4  = 1'b0;
    localparam logic PC_SEL_TARGET = 1'b1;

    // Wait counter width. MEM_TIMEOUT is limited to 255, so 8 bits suffice.
    localparam int WAIT_CNT_W = 8;

    // FETCH waits for the instruction memory, MEM waits for the data memory.
    // These are the only states in which an acknowledge is meaningful.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage : exec_sequencer_pkg

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//
// Counts consecutive cycles spent waiting for a memory acknowledge and flags a
// timeout on the MEM_TIMEOUT-th cycle without one.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset, clears the counter
//   wait_i     : high while the sequencer is in a state waiting for an ack
//   ack_i      : the acknowledge relevant to the current waiting state
//   timeout_o  : combinational; high in the cycle where the wait budget is
//                exhausted and no ack is present
//
// The counter clears whenever wait_i is low. The two waiting states are never
// adjacent in the sequencer, so every entry into a waiting state starts from
// zero without needing an explicit "entry" strobe.
// -----------------------------------------------------------------------------
module mem_wait_timer
    import exec_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ack_i,
    output logic timeout_o
);

    // Value held by the counter during the last permitted wait cycle.
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (wait_i && !ack_i) begin
            count_d = count_q + WAIT_CNT_W'(1);
        end
    end

    // An ack in the final cycle takes priority over the timeout.
    assign timeout_o = wait_i && !ack_i && (count_q == LAST_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : mem_wait_timer

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Multi-cycle control sequencer for a simple load/store core:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH ..., with HALT as the
// stop state for halt requests, illegal opcodes and memory timeouts.
//
// Parameters:
//   DWIDTH       : width of the retired-instruction counter
//   MEM_TIMEOUT  : maximum cycles to wait for an imem/dmem acknowledge (1..255)
//
// Ports:
//   clk, reset           : clock and asynchronous active-low reset
//   run_i                : start from IDLE; must be dropped to leave HALT
//   halt_i               : stop request, honoured at the WB boundary only
//   memren_i, memwren_i  : current instruction reads / writes data memory
//   regwren_i            : current instruction writes the register file
//   pcsel_i              : unconditional jump to target
//   isbranch_i,brtaken_i : conditional branch and its comparator result
//   illegal_i            : undecodable opcode
//   imem_ack_i           : instruction data valid (FETCH only)
//   dmem_ack_i           : data access complete (MEM only)
//   imem_req_o           : instruction fetch request
//   dmem_req_o,dmem_we_o : data request and write qualifier
//   ir_we_o              : capture instruction register (FETCH, on ack)
//   pc_we_o, pc_tgt_o    : update PC, choose target (1) or PC+4 (0) (WB)
//   rf_we_o              : register file write (WB)
//   state_o              : current state encoding
//   retired_o            : retired instruction count, wraps
//   err_o                : sticky fault flag (timeout or illegal)
//
// All strobes/requests are decoded combinationally from the state register,
// so the asynchronous reset removes them immediately.
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              halt_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic              regwren_i,
    input  logic              pcsel_i,
    input  logic              brtaken_i,
    input  logic              isbranch_i,
    input  logic              illegal_i,
    input  logic              imem_ack_i,
    input  logic              dmem_ack_i,
    output logic              imem_req_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic              ir_we_o,
    output logic              pc_we_o,
    output logic              pc_tgt_o,
    output logic              rf_we_o,
    output logic [2:0]        state_o,
    output logic [DWIDTH-1:0] retired_o,
    output logic              err_o
);

    state_e            state_q;
    state_e            state_d;
    logic              err_q;
    logic              err_d;
    logic [DWIDTH-1:0] retired_q;
    logic [DWIDTH-1:0] retired_d;

    logic              wait_active;
    logic              wait_ack;
    logic              wait_timeout;

    // Only the acknowledge belonging to the current waiting state reaches the
    // timer; acks arriving in any other state are ignored.
    assign wait_active = is_wait_state(state_q);
    assign wait_ack    = (state_q == ST_FETCH) ? imem_ack_i :
                         (state_q == ST_MEM)   ? dmem_ack_i : 1'b0;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .wait_i    (wait_active),
        .ack_i     (wait_ack),
        .timeout_o (wait_timeout)
    );

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        retired_d  = retired_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_tgt_o   = PC_SEL_PLUS4;
        rf_we_o    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    // Starting a fresh run is the only non-reset way to
                    // clear a previous fault.
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end

            ST_DECODE: begin
                if (illegal_i) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = (memren_i || memwren_i) ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                // Request held stable for the whole wait.
                dmem_req_o = 1'b1;
                dmem_we_o  = memwren_i;
                if (dmem_ack_i) begin
                    state_d = ST_WB;
                end else if (wait_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end

            ST_WB: begin
                rf_we_o   = regwren_i;
                pc_we_o   = 1'b1;
                pc_tgt_o  = (pcsel_i || (isbranch_i && brtaken_i)) ?
                            PC_SEL_TARGET : PC_SEL_PLUS4;
                retired_d = retired_q + DWIDTH'(1);
                // WB is the instruction boundary: the only place halt_i
                // is looked at.
                state_d   = halt_i ? ST_HALT : ST_FETCH;
            end

            ST_HALT: begin
                // Wait for run_i to drop so a still-high run_i cannot
                // immediately restart the core.
                if (!run_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;
    assign err_o     = err_q;

endmodule : exec_sequencer
